// File: rtl/inst_mem_pkg.sv
// Shared types and constants for the instruction memory responder.
package inst_mem_pkg;
  localparam int WORD_W = 16;
  localparam logic [WORD_W-1:0] ERR_DATA_DEFAULT = 16'h0000;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD_HI = 2'd1,
    LOAD_LO = 2'd2
  } load_state_e;
endpackage

// File: rtl/inst_mem_responder_if.sv
// Fetch and program-load bundle between a fetch stage/loader (master) and the responder (slave).
interface inst_mem_responder_if #(
  parameter int ADDR_W = 8
);
  import inst_mem_pkg::*;

  logic              fetch_req;
  logic [15:0]       fetch_addr;
  logic              fetch_ready;
  logic              fetch_valid;
  logic [WORD_W-1:0] fetch_data;
  logic              fetch_err;
  logic              load_start;
  logic [ADDR_W-1:0] load_base;
  logic              load_byte_valid;
  logic [7:0]        load_byte;
  logic              load_last;
  logic              load_busy;
  logic              load_done;

  modport master (
    output fetch_req, fetch_addr, load_start, load_base, load_byte_valid, load_byte, load_last,
    input  fetch_ready, fetch_valid, fetch_data, fetch_err, load_busy, load_done
  );

  modport slave (
    input  fetch_req, fetch_addr, load_start, load_base, load_byte_valid, load_byte, load_last,
    output fetch_ready, fetch_valid, fetch_data, fetch_err, load_busy, load_done
  );
endinterface

// File: rtl/inst_mem_array.sv
// Instruction storage: one synchronous write port, one registered read port, no reset.
// The read register only updates when re_i is high, so it holds the last word read.
module inst_mem_array
  import inst_mem_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [WORD_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [WORD_W-1:0] rdata_o
);
  localparam int DEPTH = 2 ** ADDR_W;

  // Power-up contents are zero; reset deliberately leaves the array alone.
  logic [WORD_W-1:0] mem_q [DEPTH] = '{default: '0};
  logic [WORD_W-1:0] rdata_q = '0;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/inst_mem_responder.sv
// Instruction memory with a one-cycle fetch port and a byte-serial program loader.
// Fetches are refused (fetch_ready low) for the whole duration of a load.
module inst_mem_responder
  import inst_mem_pkg::*;
#(
  parameter int              ADDR_W   = 8,
  parameter logic [WORD_W-1:0] ERR_DATA = ERR_DATA_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  inst_mem_responder_if.slave  bus
);
  load_state_e       state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [7:0]        hi_q, hi_d;
  logic              done_q, done_d;
  logic              valid_q, err_q, have_q;
  logic              fetch_acc, addr_oob, mem_we;
  logic [WORD_W-1:0] rdata;

  assign fetch_acc = bus.fetch_req && (state_q == IDLE);
  assign addr_oob  = |bus.fetch_addr[15:ADDR_W];
  assign mem_we    = (state_q == LOAD_LO) && bus.load_byte_valid;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    hi_d    = hi_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.load_start) begin
          state_d = LOAD_HI;
          ptr_d   = bus.load_base;
        end
      end
      LOAD_HI: begin
        if (bus.load_byte_valid) begin
          hi_d    = bus.load_byte;
          state_d = LOAD_LO;
        end
      end
      LOAD_LO: begin
        if (bus.load_byte_valid) begin
          ptr_d = ptr_q + 1'b1;
          if (bus.load_last) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = LOAD_HI;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      hi_q    <= '0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      have_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      hi_q    <= hi_d;
      done_q  <= done_d;
      valid_q <= fetch_acc;
      if (fetch_acc) begin
        err_q  <= addr_oob;
        have_q <= 1'b1;
      end
    end
  end

  inst_mem_array #(.ADDR_W(ADDR_W)) u_array (
    .clk     (clk),
    .we_i    (mem_we),
    .waddr_i (ptr_q),
    .wdata_i ({hi_q, bus.load_byte}),
    .re_i    (fetch_acc),
    .raddr_i (bus.fetch_addr[ADDR_W-1:0]),
    .rdata_o (rdata)
  );

  // err_q and the array read register only move on an accepted fetch, so the
  // data output naturally holds between responses; have_q forces zero after reset.
  assign bus.fetch_ready = (state_q == IDLE);
  assign bus.load_busy   = (state_q != IDLE);
  assign bus.load_done   = done_q;
  assign bus.fetch_valid = valid_q;
  assign bus.fetch_err   = valid_q && err_q;
  assign bus.fetch_data  = !have_q ? '0 : (err_q ? ERR_DATA : rdata);
endmodule

// File: tb/tb_inst_mem_responder.sv
// Randomized scoreboard bench for inst_mem_responder against a word/byte-level reference model.
module tb_inst_mem_responder;
  localparam int ADDR_W = 8;
  localparam int DEPTH  = 256;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  inst_mem_responder_if #(.ADDR_W(ADDR_W)) bus ();

  inst_mem_responder #(.ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: program image, load progress as a byte count, expected responses.
  logic [15:0] m_mem [DEPTH];
  bit          m_loading;
  int          m_bytes;
  logic [7:0]  m_first;
  int          m_wr;
  bit          m_done;
  logic [15:0] m_last_data;
  logic [16:0] exp_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  initial for (int i = 0; i < DEPTH; i++) m_mem[i] = 16'h0000;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_loading   = 1'b0;
      m_bytes     = 0;
      m_first     = 8'h00;
      m_wr        = 0;
      m_done      = 1'b0;
      m_last_data = 16'h0000;
      exp_q.delete();
    end else begin
      m_done = 1'b0;
      if (bus.fetch_req && !m_loading) begin
        if (bus.fetch_addr >= 16'(DEPTH)) exp_q.push_back({1'b1, 16'h0000});
        else exp_q.push_back({1'b0, m_mem[bus.fetch_addr]});
      end
      if (!m_loading) begin
        if (bus.load_start) begin
          m_loading = 1'b1;
          m_bytes   = 0;
          m_wr      = int'(bus.load_base);
        end
      end else if (bus.load_byte_valid) begin
        if (m_bytes % 2 == 0) begin
          m_first = bus.load_byte;
        end else begin
          m_mem[m_wr] = {m_first, bus.load_byte};
          m_wr = (m_wr + 1) % DEPTH;
          if (bus.load_last) begin
            m_loading = 1'b0;
            m_done    = 1'b1;
          end
        end
        m_bytes++;
      end
    end
  end

  // Monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    logic [16:0] e;
    check("load_busy", 32'(bus.load_busy), 32'(m_loading));
    check("fetch_ready", 32'(bus.fetch_ready), 32'(!m_loading));
    check("load_done", 32'(bus.load_done), 32'(m_done));
    if (bus.fetch_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_valid", 32'(bus.fetch_valid), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("fetch_err", 32'(bus.fetch_err), 32'(e[16]));
        check("fetch_data", 32'(bus.fetch_data), 32'(e[15:0]));
        m_last_data = e[15:0];
      end
    end else begin
      check("fetch_err_idle", 32'(bus.fetch_err), 32'd0);
      check("fetch_data_hold", 32'(bus.fetch_data), 32'(m_last_data));
      if (exp_q.size() != 0) begin
        check("missing_valid", 32'(bus.fetch_valid), 32'd1);
        void'(exp_q.pop_front());
      end
    end
  end

  task automatic idle_inputs();
    bus.fetch_req = 0; bus.fetch_addr = '0; bus.load_start = 0; bus.load_base = '0;
    bus.load_byte_valid = 0; bus.load_byte = '0; bus.load_last = 0;
  endtask

  task automatic step();
    @(posedge clk); #1;
    idle_inputs();
  endtask

  task automatic fetch(input logic [15:0] a);
    bus.fetch_req = 1; bus.fetch_addr = a;
    step();
  endtask

  task automatic send_byte(input logic [7:0] b, input bit last);
    bus.load_byte_valid = 1; bus.load_byte = b; bus.load_last = last;
    step();
  endtask

  task automatic start_load(input logic [7:0] base);
    bus.load_start = 1; bus.load_base = base;
    step();
  endtask

  initial begin
    idle_inputs();
    rst_n = 0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_data", 32'(bus.fetch_data), 32'h0);
    check("reset_valid", 32'(bus.fetch_valid), 32'h0);
    rst_n = 1;

    fetch(16'h0005); step();

    start_load(8'h10);
    send_byte(8'h12, 0); send_byte(8'h34, 0);
    fetch(16'h0010);
    send_byte(8'hAB, 1); step();
    send_byte(8'hCD, 1); step();
    fetch(16'h0011); fetch(16'h0010); step();

    start_load(8'hFF);
    send_byte(8'h11, 1); send_byte(8'h22, 0);
    send_byte(8'h33, 0); send_byte(8'h44, 1);
    fetch(16'h00FF); fetch(16'h0000); fetch(16'h0001);

    fetch(16'h0100); fetch(16'h0010); fetch(16'hFFFF); step();

    start_load(8'h20);
    send_byte(8'h55, 0);
    #2 rst_n = 0; #2 rst_n = 1;
    step();
    check("busy_after_reset", 32'(bus.load_busy), 32'd0);
    start_load(8'h20);
    send_byte(8'h77, 0); send_byte(8'h88, 1);
    fetch(16'h0020); step();

    bus.load_start = 1; bus.load_base = 8'h40;
    bus.fetch_req = 1; bus.fetch_addr = 16'h0010;
    step();
    send_byte(8'h9A, 0); send_byte(8'hBC, 1);
    fetch(16'h0040); step();

    for (int n = 0; n < 3000; n++) begin
      bus.fetch_req = ($urandom_range(0, 9) < 6);
      bus.fetch_addr = ($urandom_range(0, 9) < 8) ? 16'($urandom_range(0, 255))
                                                 : 16'($urandom);
      bus.load_start = ($urandom_range(0, 19) == 0);
      bus.load_base = 8'($urandom);
      bus.load_byte_valid = ($urandom_range(0, 2) != 0);
      bus.load_byte = 8'($urandom);
      bus.load_last = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 399) == 0) begin
        #2 rst_n = 0; #2 rst_n = 1;
      end
      @(posedge clk); #1;
    end
    idle_inputs();
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/inst_mem_responder.md
INST_MEM_RESPONDER -- requirements
Module: inst_mem_responder

Interface
REQ-001 Parameter: ADDR_W, default 8, word-address width; memory depth is 2**ADDR_W 16-bit words.
REQ-002 Parameter: ERR_DATA, default 16'h0000, instruction word returned for out-of-range fetches.
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 fetch_req  in  1  fetch request from the fetch stage.
REQ-006 fetch_addr  in  16  word address (PC) of the requested instruction.
REQ-007 fetch_ready  out  1  high when a fetch request is accepted this cycle.
REQ-008 fetch_valid  out  1  response strobe; fetch_data and fetch_err are valid while it is high.
REQ-009 fetch_data  out  16  instruction word.
REQ-010 fetch_err  out  1  high when the responded address was out of range.
REQ-011 load_start  in  1  begin a program load at load_base.
REQ-012 load_base  in  ADDR_W  first word address of the load.
REQ-013 load_byte_valid  in  1  load_byte is valid this cycle.
REQ-014 load_byte  in  8  program byte, high byte of each word first.
REQ-015 load_last  in  1  qualifies the final byte of the load.
REQ-016 load_busy  out  1  high while a load is in progress.
REQ-017 load_done  out  1  one-cycle pulse when the last word is written.

Function
REQ-018 Load FSM states: IDLE, LOAD_HI, LOAD_LO. fetch_ready SHALL equal (state==IDLE); load_busy SHALL equal (state!=IDLE).
REQ-019 IDLE + load_start: go to LOAD_HI and set write pointer = load_base. load_start in any other state SHALL be ignored.
REQ-020 LOAD_HI + load_byte_valid: capture the byte as the high byte and go to LOAD_LO. load_last SHALL be ignored in LOAD_HI.
REQ-021 LOAD_LO + load_byte_valid: write {high byte, load_byte} at the pointer and increment the pointer modulo 2**ADDR_W (the top address wraps to 0).
REQ-022 After the LOAD_LO write: if load_last is high, go to IDLE and pulse load_done in the next cycle; otherwise go to LOAD_HI.
REQ-023 A cycle without load_byte_valid SHALL hold the state, the pointer and the captured byte.
REQ-024 A fetch is accepted when fetch_req && fetch_ready. Exactly one cycle later: fetch_valid=1 and fetch_data = mem[fetch_addr[ADDR_W-1:0]].
REQ-025 fetch_valid SHALL be low in every cycle not preceded by an accepted fetch. A request made while fetch_ready is low SHALL be dropped, with no response.
REQ-026 If fetch_addr[15:ADDR_W] is nonzero, the response SHALL be fetch_data=ERR_DATA with fetch_err=1. fetch_err SHALL be 0 in every other case.
REQ-027 If load_start and an accepted fetch occur in the same cycle, the fetch response SHALL carry the pre-load contents and the load SHALL start normally.
REQ-028 Back-to-back fetches in IDLE SHALL sustain one response per cycle.
REQ-029 fetch_data SHALL hold its last value while fetch_valid is low.

Reset
REQ-030 On rst_n low: state=IDLE, pointer=0, captured byte=0, fetch_valid=0, fetch_data=16'h0000, fetch_err=0, load_done=0.
REQ-031 Memory contents SHALL NOT be cleared by reset. Simulation SHALL initialise the memory to all zeros.
REQ-032 Reset mid-load: any partial (high-byte-only) word SHALL be discarded, and words already written SHALL be retained.
REQ-033 Reset deassertion SHALL take effect synchronously to clk. The first fetch SHALL be acceptable in the first cycle after deassertion.

Structure
REQ-034 Shared package inst_mem_pkg SHALL hold the FSM state enum, the default ERR_DATA constant and the 16-bit word width.
REQ-035 The storage array SHALL be sub-module inst_mem_array: one synchronous write port, one registered read port, and no reset.
REQ-036 The FSM, the pointer, the range check and the output registers SHALL reside in inst_mem_responder.

Verification
REQ-037 Reset, then fetch addr 0x0005 -> next cycle fetch_valid=1, fetch_data=0x0000, fetch_err=0.
REQ-038 load_start with base 0x10, bytes 12,34,AB,CD (last on CD) -> mem[0x10]=0x1234, mem[0x11]=0xABCD, one load_done pulse. Then fetch 0x0011 -> 0xABCD.
REQ-039 During a load, fetch 0x0010 -> fetch_ready=0 and no fetch_valid. Also load base 0xFF with 2 words -> writes land at 0xFF then 0x00 (wrap).
REQ-040 Fetch 0x0100 with ADDR_W=8 -> fetch_err=1, fetch_data=0x0000. The following fetch of 0x0010 -> fetch_err=0.
REQ-041 rst_n low after only the high byte 0x55 -> IDLE, load_busy=0. A new load of 0x7788 at 0x20 reads back 0x7788, with no stale 0x55.
REQ-042 load_start with a same-cycle fetch of 0x0010 (holding 0x1234) -> response 0x1234, and load_busy=1 in the next cycle.
